// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, resolve/redirect and statistics
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);
  localparam int IDX = $clog2(ENTRIES);
  localparam int TW = 30 - IDX;
  logic            valid_q [ENTRIES];
  logic [TW-1:0]   tag_q   [ENTRIES];
  logic [31:0]     target_q[ENTRIES];
  logic [1:0]      ctr_q   [ENTRIES];
  logic [31:0]     bc_q, bc_d, mc_q, mc_d;
  logic [IDX-1:0]  if_idx, ex_idx;
  logic [TW-1:0]   if_tag, ex_tag;
  logic            if_hit, ex_hit, res, wr_en;
  logic [1:0]      ctr_d;
  logic [31:0]     tgt_d;
  logic            unused_bits;
  assign unused_bits = ^{if_pc[1:0], ex_pc[1:0]};
  assign if_idx = if_pc[IDX+1:2];
  assign if_tag = if_pc[31:IDX+2];
  assign ex_idx = ex_pc[IDX+1:2];
  assign ex_tag = ex_pc[31:IDX+2];
  // Lookup, resolve and training next-state; table reads see pre-update contents
  always_comb begin
    if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken = if_hit && ctr_q[if_idx][1];
    pred_target = pred_taken ? target_q[if_idx] : if_pc + 32'd4;
    res = ex_valid && ex_branch;
    mispredict = res && ((ex_taken != ex_pred_taken) ||
                 (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
    redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
    ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    wr_en = res && (ex_hit || ex_taken);
    ctr_d = !ex_hit ? 2'b10 :
            ex_taken ? ((ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'b01) :
                       ((ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'b01);
    tgt_d = ex_taken ? ex_target : target_q[ex_idx];
    bc_d = (res && (bc_q != '1)) ? bc_q + 32'd1 : bc_q;
    mc_d = (mispredict && (mc_q != '1)) ? mc_q + 32'd1 : mc_q;
  end
  // Table and statistics state; reset wins over any same-edge update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i] <= '0;
        target_q[i] <= '0;
        ctr_q[i] <= 2'b01;
      end
      bc_q <= '0;
      mc_q <= '0;
    end else begin
      if (wr_en) begin
        valid_q[ex_idx] <= 1'b1;
        tag_q[ex_idx] <= ex_tag;
        target_q[ex_idx] <= tgt_d;
        ctr_q[ex_idx] <= ctr_d;
      end
      bc_q <= bc_d;
      mc_q <= mc_d;
    end
  end
  assign branch_count = bc_q;
  assign mispredict_count = mc_q;
endmodule
